// File: rtl/booth_seq_divider.sv
// Iterative signed restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Sign-magnitude datapath; the result signs are applied in a final SIGN cycle.
module booth_seq_divider #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic [2*W-1:0]   quotient,
  output logic [W-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(2 * W);
  localparam logic [CW-1:0]  LAST_ITER = CW'(2 * W - 1);
  localparam logic [2*W-1:0] MIN_DVD   = {1'b1, {(2*W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2*W-1:0] dq;      // dividend magnitude shifting out, quotient bits shifting in
  logic [W:0]     dmag;
  logic [W-1:0]   prem;
  logic [CW-1:0]  cnt;
  logic           sign_q, sign_r, dz, ov;

  logic           ld, step, fin;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   prem_nxt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CALC;
      S_CALC: if (cnt == LAST_ITER) state_nxt = S_SIGN;
      S_SIGN: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control strobes decoded from the state
  always_comb begin
    ld   = 1'b0;
    step = 1'b0;
    fin  = 1'b0;
    case (state)
      S_IDLE: ld   = start;
      S_CALC: step = 1'b1;
      S_SIGN: fin  = 1'b1;
      default: ;
    endcase
  end

  // Restoring step: prem < dmag <= 2^W, so the shifted value fits W+1 bits and the
  // kept remainder always fits W bits.
  always_comb begin
    shifted  = {prem, dq[2*W-1]};
    ge       = (shifted >= dmag);
    prem_nxt = ge ? W'(shifted - dmag) : shifted[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq          <= '0;
      dmag        <= '0;
      prem        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= fin;

      if (ld) begin
        // Magnitudes taken one bit wider so the most-negative operands negate correctly
        dq     <= (2*W)'(dividend[2*W-1] ? -{dividend[2*W-1], dividend}
                                         :  {dividend[2*W-1], dividend});
        dmag   <= divisor[W-1] ? -{divisor[W-1], divisor} : {divisor[W-1], divisor};
        sign_q <= dividend[2*W-1] ^ divisor[W-1];
        sign_r <= dividend[2*W-1];
        dz     <= (divisor == '0);
        ov     <= (dividend == MIN_DVD) && (divisor == '1);
        prem   <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end

      if (step) begin
        prem <= prem_nxt;
        dq   <= {dq[2*W-2:0], ge};
        cnt  <= cnt + CW'(1);
      end

      if (fin) begin
        quotient    <= dz ? '0 : (sign_q ? -dq : dq);
        remainder   <= dz ? '0 : (sign_r ? -prem : prem);
        div_by_zero <= dz;
        overflow    <= ov;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboard bench for booth_seq_divider: stimulus pushes expected results computed with
// plain integer division; a monitor pops and compares on every done pulse.
module tb_booth_seq_divider;
  localparam int W = 8;
  localparam int LAT = 2 * W + 2;  // cycles from issue (before edge k) to done sample

  logic             clk;
  logic             reset;
  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic [2*W-1:0]   quotient;
  logic [W-1:0]     remainder;
  logic             busy, done, div_by_zero, overflow;

  booth_seq_divider #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dz;
    logic           ov;
    int             t0;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int t0);
    exp_t e;
    e.t0 = t0;
    e.ov = (a == -32768) && (b == -1);
    if (b == 0) begin
      e.q  = '0;
      e.r  = '0;
      e.dz = 1'b1;
    end else begin
      e.q  = 16'(a / b);
      e.r  = 8'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor
  logic done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_width", 32'(done_prev), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(quotient), 32'(e.q));
          check("remainder", 32'(remainder), 32'(e.r));
          check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          check("overflow", 32'(overflow), 32'(e.ov));
          check("latency", 32'(cyc - e.t0), 32'(LAT));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issues one operation at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int a, input int b, input bit expect_done);
    wait_idle();
    dividend = 16'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    if (expect_done) sb.push_back(model(a, b, cyc));
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    check({tag, "_ov"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic signs and boundary operands
    issue(100, 7, 1'b1);
    issue(-100, 7, 1'b1);
    issue(100, -7, 1'b1);
    issue(-100, -7, 1'b1);
    issue(-32768, -1, 1'b1);
    issue(-32768, -128, 1'b1);
    issue(32767, 127, 1'b1);

    // Divide by zero, then outputs hold while the next op runs
    issue(5, 0, 1'b1);
    drain();
    issue(9, 3, 1'b1);
    check("hold_quotient", 32'(quotient), 32'd0);
    check("hold_dz", 32'(div_by_zero), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    drain();

    // Start re-pulsed while busy must be ignored
    issue(100, 7, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      check("busy_during_op", 32'(busy), 32'd1);
      if (i == 3 || i == 15) begin
        dividend = 16'd1000;
        divisor  = 8'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset in the middle of CALC aborts without a done pulse
    issue(1000, 3, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    issue(-16256, -128, 1'b1);
    drain();

    // Randomized operands with bias toward corner divisors/dividends
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 0;
        1:       b = -1;
        2:       b = -128;
        default: b = int'($signed(8'($urandom)));
      endcase
      if ($urandom_range(0, 7) == 0) a = -32768;
      else a = int'($signed(16'($urandom)));
      issue(a, b, 1'b1);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
